// File: rtl/lsu_stage_if.sv
// Port bundle of the memory-access stage: upstream EX/LS packet, data bus, and LS/WB packet.
// master = the stage itself, slave = the surrounding pipeline/memory.
interface lsu_stage_if #(
   parameter int CPU_WIDTH = 64,
   parameter int REG_ADDRW = 5,
   parameter int INS_WIDTH = 32
);
   logic                   mem_valid_i;
   logic                   mem_ready_o;
   logic [CPU_WIDTH-1:0]   i_lsu_exres;
   logic [CPU_WIDTH-1:0]   i_lsu_rs2;
   logic [REG_ADDRW-1:0]   i_lsu_rdid;
   logic                   i_lsu_rdwen;
   logic [2:0]             i_lsu_func3;
   logic                   i_lsu_lden;
   logic                   i_lsu_sten;
   logic [CPU_WIDTH-1:0]   s_lsu_diffpc;
   logic [INS_WIDTH-1:0]   s_lsu_diffins;

   logic                   o_dbus_valid;
   logic                   i_dbus_ready;
   logic                   o_dbus_we;
   logic [CPU_WIDTH-1:0]   o_dbus_addr;
   logic [CPU_WIDTH-1:0]   o_dbus_wdata;
   logic [CPU_WIDTH/8-1:0] o_dbus_wmask;
   logic                   i_dbus_rvalid;
   logic [CPU_WIDTH-1:0]   i_dbus_rdata;

   logic                   wb_valid_o;
   logic                   wb_ready_i;
   logic [CPU_WIDTH-1:0]   o_wb_res;
   logic [REG_ADDRW-1:0]   o_wb_rdid;
   logic                   o_wb_rdwen;
   logic [CPU_WIDTH-1:0]   s_wb_diffpc;
   logic [INS_WIDTH-1:0]   s_wb_diffins;

   modport master (
      input  mem_valid_i, i_lsu_exres, i_lsu_rs2, i_lsu_rdid, i_lsu_rdwen, i_lsu_func3,
             i_lsu_lden, i_lsu_sten, s_lsu_diffpc, s_lsu_diffins,
             i_dbus_ready, i_dbus_rvalid, i_dbus_rdata, wb_ready_i,
      output mem_ready_o, o_dbus_valid, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_wmask,
             wb_valid_o, o_wb_res, o_wb_rdid, o_wb_rdwen, s_wb_diffpc, s_wb_diffins
   );

   modport slave (
      output mem_valid_i, i_lsu_exres, i_lsu_rs2, i_lsu_rdid, i_lsu_rdwen, i_lsu_func3,
             i_lsu_lden, i_lsu_sten, s_lsu_diffpc, s_lsu_diffins,
             i_dbus_ready, i_dbus_rvalid, i_dbus_rdata, wb_ready_i,
      input  mem_ready_o, o_dbus_valid, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_wmask,
             wb_valid_o, o_wb_res, o_wb_rdid, o_wb_rdwen, s_wb_diffpc, s_wb_diffins
   );
endinterface

// File: rtl/lsu_stage.sv
// Memory-access pipeline stage: one load/store per packet on the data bus, lane formatting
// of store data/mask and load results, non-memory results passed through.
module lsu_stage #(
   parameter int CPU_WIDTH = 64,
   parameter int REG_ADDRW = 5,
   parameter int INS_WIDTH = 32
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   lsu_stage_if.master bus
);
   localparam int LANES = CPU_WIDTH / 8;
   localparam int OFFW  = $clog2(LANES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t               state_q, state_d;
   logic [CPU_WIDTH-1:0] addr_q, rs2_q, res_q, pc_q;
   logic [INS_WIDTH-1:0] ins_q;
   logic [REG_ADDRW-1:0] rdid_q;
   logic                 rdwen_q, load_q, store_q;
   logic [2:0]           func3_q;

   logic                 accept;
   logic                 mem_op_in;
   logic                 load_done;
   logic [OFFW-1:0]      off;
   logic [CPU_WIDTH-1:0] ld_shift;
   logic [CPU_WIDTH-1:0] ld_fmt;
   logic [LANES-1:0]     base_mask;

   assign mem_op_in = bus.i_lsu_lden | bus.i_lsu_sten;
   assign accept    = bus.mem_valid_i & bus.mem_ready_o;
   assign off       = addr_q[OFFW-1:0];

   // A load finishes either on the grant cycle (rvalid together with ready) or in WAIT.
   assign load_done = load_q & bus.i_dbus_rvalid &
                      (((state_q == REQ) & bus.i_dbus_ready) | (state_q == WAIT));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = mem_op_in ? REQ : DONE;
         end
         REQ: begin
            if (bus.i_dbus_ready) begin
               if (!load_q || bus.i_dbus_rvalid) state_d = DONE;
               else                              state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.i_dbus_rvalid) state_d = DONE;
         end
         DONE: begin
            if (bus.wb_ready_i) begin
               if (accept) state_d = mem_op_in ? REQ : DONE;
               else        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_ready_o  = 1'b0;
      bus.o_dbus_valid = 1'b0;
      bus.wb_valid_o   = 1'b0;
      unique case (state_q)
         IDLE: bus.mem_ready_o = 1'b1;
         REQ:  bus.o_dbus_valid = 1'b1;
         DONE: begin
            bus.wb_valid_o  = 1'b1;
            bus.mem_ready_o = bus.wb_ready_i;
         end
         default: ;
      endcase
   end

   // Packet registers; a packet with both lden and sten is handled as a load.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         addr_q  <= '0;
         rs2_q   <= '0;
         res_q   <= '0;
         pc_q    <= '0;
         ins_q   <= '0;
         rdid_q  <= '0;
         rdwen_q <= 1'b0;
         load_q  <= 1'b0;
         store_q <= 1'b0;
         func3_q <= '0;
      end else if (accept) begin
         addr_q  <= bus.i_lsu_exres;
         rs2_q   <= bus.i_lsu_rs2;
         res_q   <= bus.i_lsu_exres;
         pc_q    <= bus.s_lsu_diffpc;
         ins_q   <= bus.s_lsu_diffins;
         rdid_q  <= bus.i_lsu_rdid;
         rdwen_q <= bus.i_lsu_rdwen;
         load_q  <= bus.i_lsu_lden;
         store_q <= bus.i_lsu_sten & ~bus.i_lsu_lden;
         func3_q <= bus.i_lsu_func3;
      end else if (load_done) begin
         res_q   <= ld_fmt;
      end
   end

   // Lane gi is written when the access size (log2 bytes) reaches the lane's minimum size.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      localparam logic [1:0] MIN_SZ = (gi < 1) ? 2'd0 : (gi < 2) ? 2'd1 : (gi < 4) ? 2'd2 : 2'd3;
      assign base_mask[gi] = (func3_q[1:0] >= MIN_SZ);
   end

   assign bus.o_dbus_we    = store_q;
   assign bus.o_dbus_addr  = {addr_q[CPU_WIDTH-1:OFFW], {OFFW{1'b0}}};
   assign bus.o_dbus_wmask = base_mask << off;
   assign bus.o_dbus_wdata = rs2_q << {off, 3'b000};

   assign ld_shift = bus.i_dbus_rdata >> {off, 3'b000};

   always_comb begin
      ld_fmt = ld_shift;
      case (func3_q)
         3'b000:  ld_fmt = {{(CPU_WIDTH-8){ld_shift[7]}},   ld_shift[7:0]};
         3'b001:  ld_fmt = {{(CPU_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
         3'b010:  ld_fmt = {{(CPU_WIDTH-32){ld_shift[31]}}, ld_shift[31:0]};
         3'b100:  ld_fmt = {{(CPU_WIDTH-8){1'b0}},          ld_shift[7:0]};
         3'b101:  ld_fmt = {{(CPU_WIDTH-16){1'b0}},         ld_shift[15:0]};
         3'b110:  ld_fmt = {{(CPU_WIDTH-32){1'b0}},         ld_shift[31:0]};
         default: ld_fmt = ld_shift;
      endcase
   end

   assign bus.o_wb_res     = res_q;
   assign bus.o_wb_rdid    = rdid_q;
   assign bus.o_wb_rdwen   = rdwen_q;
   assign bus.s_wb_diffpc  = pc_q;
   assign bus.s_wb_diffins = ins_q;
endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: table of load/store/pass-through vectors checked through a write-back
// scoreboard, plus hand sequences for back-to-back, downstream stall and reset in WAIT.
module tb_lsu_stage;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lsu_stage_if bus_if ();
   lsu_stage dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_if));

   typedef struct {
      logic        ld, st, same, chk_res, chk_wr;
      logic [2:0]  f3;
      logic [63:0] exres, rs2, rdata;
      int          hold;
      logic [63:0] exp_res, exp_addr, exp_wdata;
      logic [7:0]  exp_mask;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic        chk_res;
      logic [4:0]  rdid;
      logic        rdwen;
      logic [63:0] pc;
      logic [31:0] ins;
   } sb_t;

   sb_t  sb_q[$];
   vec_t vecs[16];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   seq_id = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [63:0] exres, input logic [63:0] rs2,
                               input logic [63:0] rdata, input logic same, input int hold,
                               input logic [63:0] exp_res, input logic [63:0] exp_addr,
                               input logic [7:0] exp_mask, input logic [63:0] exp_wdata,
                               input logic chk_wr);
      vec_t v;
      v.ld = ld;  v.st = st;  v.f3 = f3;  v.exres = exres;  v.rs2 = rs2;  v.rdata = rdata;
      v.same = same;  v.hold = hold;  v.exp_res = exp_res;  v.exp_addr = exp_addr;
      v.exp_mask = exp_mask;  v.exp_wdata = exp_wdata;  v.chk_wr = chk_wr;
      v.chk_res = ld | ~st;
      return v;
   endfunction

   // Write-back monitor: every handshake pops one expected packet.
   always @(negedge clk) begin : wb_monitor
      sb_t e;
      if (rst_n && bus_if.wb_valid_o && bus_if.wb_ready_i) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wb_unexpected: got packet res=0x%016h, required no packet", bus_if.o_wb_res);
         end else begin
            e = sb_q.pop_front();
            $display("wb txn: res=0x%016h rd=%0d wen=%0d pc=0x%016h", bus_if.o_wb_res,
                     bus_if.o_wb_rdid, bus_if.o_wb_rdwen, bus_if.s_wb_diffpc);
            if (e.chk_res) check("wb_res", bus_if.o_wb_res, e.res);
            check("wb_rd", {bus_if.o_wb_rdid, bus_if.o_wb_rdwen}, {e.rdid, e.rdwen});
            check("wb_pc", bus_if.s_wb_diffpc, e.pc);
            check("wb_ins", bus_if.s_wb_diffins, e.ins);
         end
      end
   end

   task automatic set_pkt(input logic [63:0] exres, input logic [63:0] rs2, input logic [2:0] f3,
                          input logic ld, input logic st, input logic [4:0] rdid,
                          input logic [63:0] exp_res, input logic chk_res, output sb_t e);
      bus_if.i_lsu_exres   = exres;
      bus_if.i_lsu_rs2     = rs2;
      bus_if.i_lsu_func3   = f3;
      bus_if.i_lsu_lden    = ld;
      bus_if.i_lsu_sten    = st;
      bus_if.i_lsu_rdid    = rdid;
      bus_if.i_lsu_rdwen   = ~st | ld;
      bus_if.s_lsu_diffpc  = 64'h8000_0000 + 64'(seq_id * 4);
      bus_if.s_lsu_diffins = 32'h13 | 32'(seq_id << 7);
      e.res = exp_res;  e.chk_res = chk_res;  e.rdid = rdid;  e.rdwen = ~st | ld;
      e.pc = bus_if.s_lsu_diffpc;  e.ins = bus_if.s_lsu_diffins;
      seq_id++;
   endtask

   task automatic send(input logic [63:0] exres, input logic [63:0] rs2, input logic [2:0] f3,
                       input logic ld, input logic st, input logic [4:0] rdid,
                       input logic push_it, input logic [63:0] exp_res, input logic chk_res);
      sb_t e;
      int  guard = 0;
      bit  ok = 0;
      set_pkt(exres, rs2, f3, ld, st, rdid, exp_res, chk_res, e);
      bus_if.mem_valid_i = 1'b1;
      while (!ok && guard < 20) begin
         @(negedge clk);
         if (bus_if.mem_ready_o) begin
            ok = 1;
            if (push_it) sb_q.push_back(e);
         end
         step();
         guard++;
      end
      bus_if.mem_valid_i = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: got mem_ready_o=0 for 20 cycles, required 1");
      end
   endtask

   task automatic do_mem(input vec_t v);
      int guard = 0;
      while (!bus_if.o_dbus_valid && guard < 10) begin
         step();
         guard++;
      end
      check("dbus_valid", bus_if.o_dbus_valid, 1'b1);
      if (!bus_if.o_dbus_valid) return;
      check("dbus_addr", bus_if.o_dbus_addr, v.exp_addr);
      check("dbus_we", bus_if.o_dbus_we, v.ld ? 1'b0 : 1'b1);
      if (v.chk_wr) begin
         check("dbus_wmask", bus_if.o_dbus_wmask, v.exp_mask);
         check("dbus_wdata", bus_if.o_dbus_wdata, v.exp_wdata);
      end
      for (int k = 0; k < v.hold; k++) step();
      if (v.hold > 0) begin
         check("req_stable_valid", bus_if.o_dbus_valid, 1'b1);
         check("req_stable_addr", bus_if.o_dbus_addr, v.exp_addr);
         if (v.chk_wr) check("req_stable_wdata", bus_if.o_dbus_wdata, v.exp_wdata);
      end
      bus_if.i_dbus_ready = 1'b1;
      if (v.ld && v.same) begin
         bus_if.i_dbus_rvalid = 1'b1;
         bus_if.i_dbus_rdata  = v.rdata;
      end
      step();
      bus_if.i_dbus_ready  = 1'b0;
      bus_if.i_dbus_rvalid = 1'b0;
      bus_if.i_dbus_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
      if (v.ld && !v.same) begin
         bus_if.i_dbus_rvalid = 1'b1;
         bus_if.i_dbus_rdata  = v.rdata;
         step();
         bus_if.i_dbus_rvalid = 1'b0;
         bus_if.i_dbus_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (sb_q.size() != 0 && guard < 10) begin
         step();
         guard++;
      end
      check("sb_drained", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no completion within 200000 time units, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      sb_t e;
      vecs[0]  = mk(0, 1, 3'b000, 64'h8000_0005, 64'hAB, 64'h0, 0, 3, 64'h0,
                    64'h8000_0000, 8'h20, 64'h0000_AB00_0000_0000, 1);
      vecs[1]  = mk(1, 0, 3'b000, 64'h1002, 64'h5555, 64'h0000_0000_0080_0000, 0, 0,
                    64'hFFFF_FFFF_FFFF_FF80, 64'h1000, 8'h0, 64'h0, 0);
      vecs[2]  = mk(1, 0, 3'b100, 64'h1002, 64'h5555, 64'h0000_0000_0080_0000, 0, 0,
                    64'h80, 64'h1000, 8'h0, 64'h0, 0);
      vecs[3]  = mk(1, 0, 3'b010, 64'h2004, 64'h0, 64'h8765_4321_0000_0000, 0, 1,
                    64'hFFFF_FFFF_8765_4321, 64'h2000, 8'h0, 64'h0, 0);
      vecs[4]  = mk(1, 0, 3'b110, 64'h2004, 64'h0, 64'h8765_4321_0000_0000, 0, 0,
                    64'h0000_0000_8765_4321, 64'h2000, 8'h0, 64'h0, 0);
      vecs[5]  = mk(0, 1, 3'b001, 64'h3006, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 64'h0,
                    64'h3000, 8'hC0, 64'h7788_0000_0000_0000, 1);
      vecs[6]  = mk(0, 1, 3'b011, 64'h4000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 2, 64'h0,
                    64'h4000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1);
      vecs[7]  = mk(0, 1, 3'b010, 64'h5006, 64'h1122_3344, 64'h0, 0, 0, 64'h0,
                    64'h5000, 8'hC0, 64'h3344_0000_0000_0000, 1);
      vecs[8]  = mk(1, 0, 3'b001, 64'h6006, 64'h0, 64'h9ABC_0000_0000_0000, 0, 0,
                    64'hFFFF_FFFF_FFFF_9ABC, 64'h6000, 8'h0, 64'h0, 0);
      vecs[9]  = mk(1, 0, 3'b101, 64'h6006, 64'h0, 64'h9ABC_0000_0000_0000, 0, 0,
                    64'h9ABC, 64'h6000, 8'h0, 64'h0, 0);
      vecs[10] = mk(1, 0, 3'b011, 64'h7000, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0,
                    64'h0123_4567_89AB_CDEF, 64'h7000, 8'h0, 64'h0, 0);
      vecs[11] = mk(1, 0, 3'b111, 64'h7001, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0,
                    64'h0001_2345_6789_ABCD, 64'h7000, 8'h0, 64'h0, 0);
      vecs[12] = mk(1, 1, 3'b100, 64'h8003, 64'h77, 64'h0000_0000_FF00_0000, 0, 0,
                    64'hFF, 64'h8000, 8'h0, 64'h0, 0);
      vecs[13] = mk(0, 1, 3'b110, 64'h9000, 64'hAABB_CCDD, 64'h0, 0, 0, 64'h0,
                    64'h9000, 8'h0F, 64'h0000_0000_AABB_CCDD, 1);
      vecs[14] = mk(1, 0, 3'b000, 64'hA000, 64'h0, 64'h7F, 1, 1,
                    64'h7F, 64'hA000, 8'h0, 64'h0, 0);
      vecs[15] = mk(0, 0, 3'b011, 64'h5555, 64'h0, 64'h0, 0, 0,
                    64'h5555, 64'h0, 8'h0, 64'h0, 0);

      rst_n = 1'b0;
      bus_if.mem_valid_i   = 1'b0;
      bus_if.i_dbus_ready  = 1'b0;
      bus_if.i_dbus_rvalid = 1'b0;
      bus_if.i_dbus_rdata  = 64'h0;
      bus_if.wb_ready_i    = 1'b1;
      set_pkt(64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, e);
      repeat (3) step();
      check("rst_wb_valid", bus_if.wb_valid_o, 1'b0);
      check("rst_dbus_valid", bus_if.o_dbus_valid, 1'b0);
      check("rst_wb_fields", {bus_if.o_wb_res, bus_if.o_wb_rdid, bus_if.o_wb_rdwen},
            64'h0);
      check("rst_wb_diff", bus_if.s_wb_diffpc | 64'(bus_if.s_wb_diffins), 64'h0);
      rst_n = 1'b1;
      step();
      check("idle_mem_ready", bus_if.mem_ready_o, 1'b1);

      // Pass-through latency and back-to-back throughput.
      send(64'h1234, 64'h0, 3'b000, 0, 0, 5'd5, 1, 64'h1234, 1);
      check("np_valid_next", bus_if.wb_valid_o, 1'b1);
      check("np_res", bus_if.o_wb_res, 64'h1234);
      check("np_rdid", bus_if.o_wb_rdid, 5'd5);
      send(64'h2222, 64'h0, 3'b000, 0, 0, 5'd6, 1, 64'h2222, 1);
      check("b2b_valid_2", bus_if.wb_valid_o, 1'b1);
      send(64'h3333, 64'h0, 3'b000, 0, 0, 5'd7, 1, 64'h3333, 1);
      check("b2b_valid_3", bus_if.wb_valid_o, 1'b1);
      check("b2b_res_3", bus_if.o_wb_res, 64'h3333);
      step();
      check("b2b_valid_end", bus_if.wb_valid_o, 1'b0);
      check("b2b_all_out", 64'(sb_q.size()), 64'd0);

      for (int i = 0; i < 16; i++) begin
         send(vecs[i].exres, vecs[i].rs2, vecs[i].f3, vecs[i].ld, vecs[i].st, 5'(i + 1), 1,
              vecs[i].exp_res, vecs[i].chk_res);
         if (vecs[i].ld || vecs[i].st) do_mem(vecs[i]);
         drain();
      end

      // Downstream stall in DONE, then release with a new packet waiting.
      bus_if.wb_ready_i = 1'b0;
      send(64'hAAAA, 64'h0, 3'b000, 0, 0, 5'd9, 1, 64'hAAAA, 1);
      set_pkt(64'hBBBB, 64'h0, 3'b000, 1'b0, 1'b0, 5'd10, 64'hBBBB, 1'b1, e);
      bus_if.mem_valid_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("stall_res", {63'(bus_if.o_wb_res), bus_if.wb_valid_o}, {63'hAAAA, 1'b1});
         check("stall_not_ready", bus_if.mem_ready_o, 1'b0);
         step();
      end
      bus_if.wb_ready_i = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      check("release_ready", bus_if.mem_ready_o, 1'b1);
      step();
      bus_if.mem_valid_i = 1'b0;
      check("release_new_valid", bus_if.wb_valid_o, 1'b1);
      check("release_new_res", bus_if.o_wb_res, 64'hBBBB);
      drain();

      // Reset while waiting for load data; late rvalid must be ignored.
      send(64'h2004, 64'h0, 3'b010, 1, 0, 5'd11, 0, 64'h0, 0);
      bus_if.i_dbus_ready = 1'b1;
      step();
      bus_if.i_dbus_ready = 1'b0;
      check("wait_no_req", bus_if.o_dbus_valid, 1'b0);
      check("wait_no_wb", bus_if.wb_valid_o, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("post_rst_res", bus_if.o_wb_res, 64'h0);
      bus_if.i_dbus_rvalid = 1'b1;
      bus_if.i_dbus_rdata  = 64'h8765_4321_0000_0000;
      step();
      bus_if.i_dbus_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("late_rvalid_wb", bus_if.wb_valid_o, 1'b0);
         check("late_rvalid_ready", bus_if.mem_ready_o, 1'b1);
         step();
      end
      check("final_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Memory-access stage. Consumes the EX/LS pipeline register outputs (valid/ready handshake) and produces the write-back packet for the LS/WB pipeline register (valid/ready handshake).
- Issues at most one load/store to the data bus. For stores, generates the byte mask and shifted write data. For loads, extracts and sign/zero-extends the returned data.
- Non-memory instructions pass the EX result straight through.

Parameters:
CPU_WIDTH, 64, datapath and bus data width; byte lanes = CPU_WIDTH/8.
REG_ADDRW, 5, register index width.
INS_WIDTH, 32, difftest instruction width.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
mem_valid_i  in  1  upstream packet valid
mem_ready_o  out  1  stage can accept a packet this cycle
i_lsu_exres  in  CPU_WIDTH  ALU result / effective address
i_lsu_rs2  in  CPU_WIDTH  store data
i_lsu_rdid  in  REG_ADDRW  destination register
i_lsu_rdwen  in  1  register write enable
i_lsu_func3  in  3  access size/sign
i_lsu_lden  in  1  load
i_lsu_sten  in  1  store
s_lsu_diffpc  in  CPU_WIDTH  difftest pc
s_lsu_diffins  in  INS_WIDTH  difftest instruction
o_dbus_valid  out  1  bus request
i_dbus_ready  in  1  bus accepts request
o_dbus_we  out  1  1 = write
o_dbus_addr  out  CPU_WIDTH  address, low 3 bits forced to 0
o_dbus_wdata  out  CPU_WIDTH  lane-aligned write data
o_dbus_wmask  out  CPU_WIDTH/8  byte-lane write mask
i_dbus_rvalid  in  1  read data valid
i_dbus_rdata  in  CPU_WIDTH  read data (full aligned word)
wb_valid_o  out  1  result packet valid
wb_ready_i  in  1  downstream accepts
o_wb_res  out  CPU_WIDTH  write-back value
o_wb_rdid  out  REG_ADDRW  destination register
o_wb_rdwen  out  1  register write enable
s_wb_diffpc  out  CPU_WIDTH  difftest pc
s_wb_diffins  out  INS_WIDTH  difftest instruction

Behaviour:
Reset:
- Reset is sampled on i_clk while i_rst_n==0. State goes to IDLE and all registered outputs clear to 0: o_dbus_valid=0, wb_valid_o=0, o_wb_*=0, s_wb_*=0.
- Reset mid-transaction abandons the access. An i_dbus_rvalid arriving later in IDLE is ignored.

FSM states: IDLE, REQ, WAIT, DONE.
- mem_ready_o = (IDLE) or (DONE and wb_ready_i).
- Accept = mem_valid_i and mem_ready_o. On accept, latch all inputs.
  - Next state is REQ if lden or sten is set, else DONE with o_wb_res = exres.
  - If lden and sten are both set, the access is treated as a load.
- REQ:
  - o_dbus_valid=1. Address, we, wdata and wmask stay stable until i_dbus_ready.
  - On i_dbus_ready: a store goes to DONE; a load goes to WAIT.
  - i_dbus_ready and i_dbus_rvalid in the same cycle for a load completes directly to DONE.
- WAIT: on i_dbus_rvalid, latch the formatted load result and go to DONE.
- DONE:
  - wb_valid_o=1; outputs stay stable until wb_ready_i.
  - On wb_ready_i: if a new packet is accepted in the same cycle, branch as from IDLE; else go to IDLE.
- Store: o_wb_rdwen passes through from the latched value (expected 0 from decode).

Latency:
- Non-memory instruction: wb_valid_o one cycle after accept.
- Store with immediate ready: 2 cycles.
- Load with ready then rvalid on the next cycle: 3 cycles.
- Back-to-back throughput: 1 packet/cycle for non-memory instructions.

Formatting (off = exres[2:0]):
- Store sizes by func3: 000 = B, mask 0x01; 001 = H, 0x03; 010 = W, 0x0F; 011 = D, 0xFF.
- Store mask is shifted left by off; bits beyond lane 7 are discarded. Misaligned accesses are not split.
- o_dbus_wdata = rs2 << (8*off), truncated to CPU_WIDTH.
- Load: d = rdata >> (8*off).
  - 000: sext d[7:0]; 001: sext d[15:0]; 010: sext d[31:0]; 011: d.
  - 100: zext d[7:0]; 101: zext d[15:0]; 110: zext d[31:0]; 111: d.
- Store func3 values 1xx behave as their 0xx size.

Test Plan:
1. Non-memory instruction with exres=0x1234, rdid=5, wb_ready_i=1 -> wb_valid_o is 1 the next cycle with o_wb_res=0x1234 and o_wb_rdid=5. Three back-to-back packets give 3 consecutive valid cycles.
2. SB with exres=0x80000005, rs2=0xAB -> o_dbus_addr=0x80000000, wmask=0x20, wdata[47:40]=0xAB, we=1. Hold i_dbus_ready low 3 cycles -> request stays stable; then DONE.
3. LB at offset 2 with rdata=0x0000000000800000 -> o_wb_res=0xFFFFFFFFFFFFFF80. Same access as LBU -> 0x80.
4. LW at offset 4 with rdata=0x8765432100000000 -> 0xFFFFFFFF87654321. Same access as LWU -> 0x0000000087654321.
5. wb_ready_i low for 4 cycles in DONE -> outputs stable and mem_ready_o=0. Raise wb_ready_i with mem_valid_i=1 -> new packet accepted that same cycle.
6. Assert reset while in WAIT, then pulse i_dbus_rvalid after reset -> wb_valid_o stays 0, state IDLE, mem_ready_o=1.
